// File: rtl/serial_pkg.sv
// Shared types and helpers for the serial word transmitter.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } tx_state_t;

  // Counter width that never collapses to zero bits.
  function automatic int cnt_width(input int n);
    if (n <= 1) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/serial_word_tx.sv
// Parallel-to-serial front end: one-word holding buffer, shifter and
// IDLE/SHIFT/GAP sequencer feeding a negedge-sampling shift register.
module serial_word_tx
  import serial_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int GAP_CYCLES = 0,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_en,
  output logic             word_done,
  output logic             busy
);

  localparam int BW = cnt_width(WIDTH);
  localparam int GW = cnt_width(GAP_CYCLES + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

  tx_state_t        state_r, state_s;
  logic [WIDTH-1:0] hold_r;
  logic             hold_valid_r, hold_valid_s;
  logic [WIDTH-1:0] shifter_r, shifter_s;
  logic [BW-1:0]    bit_cnt_r, bit_cnt_s;
  logic [GW-1:0]    gap_cnt_r, gap_cnt_s;
  logic             ready_en_r;
  logic             word_done_r;
  logic             load_s;
  logic             accept_s;
  logic             last_bit_s;

  assign in_ready   = ready_en_r & ~hold_valid_r;
  assign accept_s   = in_valid & in_ready;
  assign last_bit_s = (state_r == SHIFT) && (bit_cnt_r == LAST_BIT);

  assign ser_en    = (state_r == SHIFT);
  assign ser_out   = ser_en & (MSB_FIRST ? shifter_r[WIDTH-1] : shifter_r[0]);
  assign word_done = word_done_r;
  assign busy      = (state_r != IDLE) | hold_valid_r;

  // Next-state, load decision and shifter/counter updates.
  always_comb begin
    state_s   = state_r;
    shifter_s = shifter_r;
    bit_cnt_s = bit_cnt_r;
    gap_cnt_s = gap_cnt_r;
    load_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (hold_valid_r) begin
          load_s  = 1'b1;
          state_s = SHIFT;
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        if (bit_cnt_r == LAST_BIT) begin
          bit_cnt_s = '0;
          if (GAP_CYCLES > 0) begin
            state_s   = GAP;
            gap_cnt_s = GAP_LOAD;
          end else if (hold_valid_r) begin
            load_s  = 1'b1;
            state_s = SHIFT;
          end else begin
            state_s = IDLE;
          end
        end else begin
          bit_cnt_s = bit_cnt_r + BW'(1);
        end
      end
      GAP: begin
        if (gap_cnt_r == '0) begin
          state_s = IDLE;
        end else begin
          gap_cnt_s = gap_cnt_r - GW'(1);
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    // A reload replaces the shift on the same edge, so streaming has no bubble.
    if (load_s) begin
      shifter_s = hold_r;
      bit_cnt_s = '0;
    end else if (state_r == SHIFT) begin
      shifter_s = MSB_FIRST ? {shifter_r[WIDTH-2:0], 1'b0} : {1'b0, shifter_r[WIDTH-1:1]};
    end else begin
      shifter_s = shifter_r;
    end
  end

  // Holding register occupancy: a same-edge accept wins over the load.
  always_comb begin
    if (accept_s) begin
      hold_valid_s = 1'b1;
    end else if (load_s) begin
      hold_valid_s = 1'b0;
    end else begin
      hold_valid_s = hold_valid_r;
    end
  end

  // State, datapath and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      hold_r       <= '0;
      hold_valid_r <= 1'b0;
      shifter_r    <= '0;
      bit_cnt_r    <= '0;
      gap_cnt_r    <= '0;
      ready_en_r   <= 1'b0;
      word_done_r  <= 1'b0;
    end else begin
      state_r      <= state_s;
      hold_valid_r <= hold_valid_s;
      shifter_r    <= shifter_s;
      bit_cnt_r    <= bit_cnt_s;
      gap_cnt_r    <= gap_cnt_s;
      ready_en_r   <= 1'b1;
      word_done_r  <= last_bit_s;
      if (accept_s) begin
        hold_r <= in_data;
      end else begin
        hold_r <= hold_r;
      end
    end
  end

endmodule

// File: tb/tb_serial_word_tx.sv
// Self-checking bench: three transmitters (MSB/no gap, MSB/gap 2, LSB/no gap)
// checked against a word-to-bitstream model and timing rules.
module tb_serial_word_tx;

  localparam int N = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [7:0]   in_data [N];
  logic [N-1:0] in_valid;
  logic [N-1:0] in_ready, ser_out, ser_en, word_done, busy;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  logic       bit_q  [N][$];
  int         bcyc_q [N][$];
  int         done_q [N][$];
  int         viol   [N];
  logic [7:0] sr     [N];

  typedef logic bitq_t [$];
  typedef logic [7:0] wordq_t [$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < N; g++) begin : g_dut
    serial_word_tx #(
      .WIDTH(8),
      .GAP_CYCLES((g == 1) ? 2 : 0),
      .MSB_FIRST((g == 2) ? 1'b0 : 1'b1)
    ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .in_data(in_data[g]),
      .in_valid(in_valid[g]),
      .in_ready(in_ready[g]),
      .ser_out(ser_out[g]),
      .ser_en(ser_en[g]),
      .word_done(word_done[g]),
      .busy(busy[g])
    );
  end

  // Consumer-side monitor: logs qualified bits, done pulses, and a shift-left register.
  always @(negedge clk) begin
    for (int d = 0; d < N; d++) begin
      if (ser_en[d]) begin
        bit_q[d].push_back(ser_out[d]);
        bcyc_q[d].push_back(cyc);
        sr[d] <= {sr[d][6:0], ser_out[d]};
      end
      if (word_done[d]) done_q[d].push_back(cyc);
      if (!ser_en[d] && ser_out[d]) viol[d] <= viol[d] + 1;
    end
  end

  // Reference model: a word list becomes its serial bit sequence.
  function automatic bitq_t expand(input wordq_t ws, input int d);
    bitq_t q;
    q = {};
    foreach (ws[k]) begin
      for (int i = 0; i < 8; i++) q.push_back((d == 2) ? ws[k][i] : ws[k][7-i]);
    end
    return q;
  endfunction

  // Present one word at a negedge and return the posedge count that accepted it.
  task automatic send(input int d, input logic [7:0] w, output int acc);
    int t;
    t = 0;
    in_valid[d] = 1'b1;
    in_data[d]  = w;
    while (!in_ready[d] && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      checks++;
      errors++;
      $display("FAIL send_timeout dut%0d: in_ready stayed %b, required 1", d, in_ready[d]);
    end
    acc = cyc + 1;
    @(negedge clk);
    in_valid[d] = 1'b0;
    in_data[d]  = 8'($urandom);
  endtask

  task automatic wait_idle(input int d);
    int t;
    t = 0;
    while ((busy[d] || ser_en[d]) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (t >= 2000) begin
      errors++;
      $display("FAIL idle_timeout dut%0d: busy=%b, required 0", d, busy[d]);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    for (int d = 0; d < N; d++) begin
      checks++;
      if ({ser_en[d], ser_out[d], word_done[d], busy[d], in_ready[d]} !== 5'b0) begin
        errors++;
        $display("FAIL reset_outputs dut%0d: en/out/done/busy/ready=%b, required 00000", d,
                 {ser_en[d], ser_out[d], word_done[d], busy[d], in_ready[d]});
      end
    end
    rst_n = 1'b1;
    for (int d = 0; d < N; d++) begin
      checks++;
      if (in_ready[d] !== 1'b0) begin
        errors++;
        $display("FAIL ready_at_release dut%0d: got %b, required 0", d, in_ready[d]);
      end
    end
    @(negedge clk);
    for (int d = 0; d < N; d++) begin
      checks++;
      if (in_ready[d] !== 1'b1) begin
        errors++;
        $display("FAIL ready_after_release dut%0d: got %b, required 1", d, in_ready[d]);
      end
    end
  endtask

  task automatic test_single();
    int b0, d0, acc;
    wordq_t ws;
    bitq_t  exp;
    ws  = '{8'hA5};
    exp = expand(ws, 0);
    b0  = bit_q[0].size();
    d0  = done_q[0].size();
    send(0, 8'hA5, acc);
    wait_idle(0);
    checks++;
    if (bit_q[0].size() - b0 != 8) begin
      errors++;
      $display("FAIL single_len: got %0d bits, required 8", bit_q[0].size() - b0);
    end
    foreach (exp[i]) begin
      if (b0 + i < bit_q[0].size()) begin
        checks++;
        if (bit_q[0][b0+i] !== exp[i] || bcyc_q[0][b0+i] != acc + 1 + i) begin
          errors++;
          $display("FAIL single_bit%0d: got %b@%0d, required %b@%0d", i, bit_q[0][b0+i],
                   bcyc_q[0][b0+i], exp[i], acc + 1 + i);
        end
      end
    end
    checks++;
    if (done_q[0].size() - d0 != 1) begin
      errors++;
      $display("FAIL single_done_count: got %0d, required 1", done_q[0].size() - d0);
    end else begin
      checks++;
      if (done_q[0][d0] != acc + 9) begin
        errors++;
        $display("FAIL single_done_cycle: got %0d, required %0d", done_q[0][d0], acc + 9);
      end
    end
    checks++;
    if (sr[0] !== 8'hA5 || sr[0][7] !== 1'b1) begin
      errors++;
      $display("FAIL consumer_word: got %h, required a5 with sout 1", sr[0]);
    end
  endtask

  task automatic test_back_to_back();
    int b0, d0, a1, a2;
    wordq_t ws;
    bitq_t  exp;
    ws  = '{8'hA5, 8'h3C};
    exp = expand(ws, 0);
    b0  = bit_q[0].size();
    d0  = done_q[0].size();
    send(0, 8'hA5, a1);
    send(0, 8'h3C, a2);
    wait_idle(0);
    checks++;
    if (bit_q[0].size() - b0 != 16) begin
      errors++;
      $display("FAIL b2b_len: got %0d bits, required 16", bit_q[0].size() - b0);
    end
    foreach (exp[i]) begin
      if (b0 + i < bit_q[0].size()) begin
        checks++;
        if (bit_q[0][b0+i] !== exp[i] || bcyc_q[0][b0+i] != a1 + 1 + i) begin
          errors++;
          $display("FAIL b2b_bit%0d: got %b@%0d, required %b@%0d", i, bit_q[0][b0+i],
                   bcyc_q[0][b0+i], exp[i], a1 + 1 + i);
        end
      end
    end
    checks++;
    if (done_q[0].size() - d0 != 2) begin
      errors++;
      $display("FAIL b2b_done_count: got %0d, required 2", done_q[0].size() - d0);
    end else begin
      checks++;
      if (done_q[0][d0] != a1 + 9 || done_q[0][d0+1] != a1 + 17) begin
        errors++;
        $display("FAIL b2b_done_cycles: got %0d,%0d, required %0d,%0d", done_q[0][d0],
                 done_q[0][d0+1], a1 + 9, a1 + 17);
      end
    end
  endtask

  task automatic test_gap();
    int b0, d0, v0, a1, a2;
    wordq_t ws;
    bitq_t  exp;
    ws  = '{8'($urandom), 8'($urandom)};
    exp = expand(ws, 1);
    b0  = bit_q[1].size();
    d0  = done_q[1].size();
    v0  = viol[1];
    send(1, ws[0], a1);
    send(1, ws[1], a2);
    wait_idle(1);
    checks++;
    if (bit_q[1].size() - b0 != 16) begin
      errors++;
      $display("FAIL gap_len: got %0d bits, required 16", bit_q[1].size() - b0);
    end else begin
      foreach (exp[i]) begin
        checks++;
        if (bit_q[1][b0+i] !== exp[i]) begin
          errors++;
          $display("FAIL gap_bit%0d: got %b, required %b", i, bit_q[1][b0+i], exp[i]);
        end
      end
      checks++;
      if (bcyc_q[1][b0+8] - bcyc_q[1][b0+7] != 4 || bcyc_q[1][b0+7] != a1 + 8) begin
        errors++;
        $display("FAIL gap_idle: got %0d idle cycles, required 3",
                 bcyc_q[1][b0+8] - bcyc_q[1][b0+7] - 1);
      end
      checks++;
      if (done_q[1].size() - d0 != 2 || done_q[1][d0] != bcyc_q[1][b0+7] + 1) begin
        errors++;
        $display("FAIL gap_done: got %0d pulses, required 2 with first at %0d",
                 done_q[1].size() - d0, bcyc_q[1][b0+7] + 1);
      end
    end
    checks++;
    if (viol[1] != v0) begin
      errors++;
      $display("FAIL gap_ser_out_zero: got %0d cycles with ser_out=1, required 0", viol[1] - v0);
    end
  endtask

  task automatic test_backpressure();
    int b0, a1, a2, a3;
    wordq_t ws;
    bitq_t  exp;
    ws  = '{8'h11, 8'h22, 8'h33};
    exp = expand(ws, 0);
    b0  = bit_q[0].size();
    send(0, 8'h11, a1);
    send(0, 8'h22, a2);
    send(0, 8'h33, a3);
    wait_idle(0);
    checks++;
    if (a2 != a1 + 2) begin
      errors++;
      $display("FAIL bp_accept2: got edge %0d, required %0d", a2, a1 + 2);
    end
    checks++;
    if (bit_q[0].size() - b0 != 24) begin
      errors++;
      $display("FAIL bp_len: got %0d bits, required 24", bit_q[0].size() - b0);
    end else begin
      checks++;
      if (a3 != bcyc_q[0][b0+8] + 1) begin
        errors++;
        $display("FAIL bp_accept3: got edge %0d, required %0d", a3, bcyc_q[0][b0+8] + 1);
      end
      foreach (exp[i]) begin
        checks++;
        if (bit_q[0][b0+i] !== exp[i]) begin
          errors++;
          $display("FAIL bp_bit%0d: got %b, required %b", i, bit_q[0][b0+i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_lsb_first();
    int b0, d0, acc;
    b0 = bit_q[2].size();
    d0 = done_q[2].size();
    send(2, 8'h01, acc);
    wait_idle(2);
    checks++;
    if (bit_q[2].size() - b0 != 8) begin
      errors++;
      $display("FAIL lsb_len: got %0d bits, required 8", bit_q[2].size() - b0);
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (bit_q[2][b0+i] !== ((i == 0) ? 1'b1 : 1'b0)) begin
          errors++;
          $display("FAIL lsb_bit%0d: got %b, required %b", i, bit_q[2][b0+i], (i == 0));
        end
      end
    end
    checks++;
    if (done_q[2].size() - d0 != 1) begin
      errors++;
      $display("FAIL lsb_done: got %0d pulses, required 1", done_q[2].size() - d0);
    end
  endtask

  task automatic test_random();
    int b0, d0, acc;
    wordq_t ws;
    bitq_t  exp;
    for (int d = 0; d < N; d++) begin
      ws = {};
      b0 = bit_q[d].size();
      d0 = done_q[d].size();
      for (int k = 0; k < 12; k++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        ws.push_back(8'($urandom));
        send(d, ws[k], acc);
      end
      wait_idle(d);
      exp = expand(ws, d);
      checks++;
      if (bit_q[d].size() - b0 != exp.size() || done_q[d].size() - d0 != 12) begin
        errors++;
        $display("FAIL rand_len dut%0d: got %0d bits/%0d done, required %0d/12", d,
                 bit_q[d].size() - b0, done_q[d].size() - d0, exp.size());
      end else begin
        foreach (exp[i]) begin
          checks++;
          if (bit_q[d][b0+i] !== exp[i]) begin
            errors++;
            $display("FAIL rand_bit dut%0d #%0d: got %b, required %b", d, i, bit_q[d][b0+i], exp[i]);
          end
        end
        for (int k = 0; k < 12; k++) begin
          checks++;
          if (done_q[d][d0+k] != bcyc_q[d][b0+8*k+7] + 1) begin
            errors++;
            $display("FAIL rand_done dut%0d word%0d: got %0d, required %0d", d, k,
                     done_q[d][d0+k], bcyc_q[d][b0+8*k+7] + 1);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int b0, d0, acc, t;
    b0 = bit_q[0].size();
    d0 = done_q[0].size();
    t  = 0;
    send(0, 8'hFF, acc);
    while (bit_q[0].size() < b0 + 3 && t < 50) begin
      @(negedge clk);
      #1;
      t++;
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ser_en[0], ser_out[0], busy[0], in_ready[0]} !== 4'b0) begin
      errors++;
      $display("FAIL midreset_outputs: en/out/busy/ready=%b, required 0000",
               {ser_en[0], ser_out[0], busy[0], in_ready[0]});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (in_ready[0] !== 1'b0) begin
      errors++;
      $display("FAIL midreset_ready_release: got %b, required 0", in_ready[0]);
    end
    @(negedge clk);
    checks++;
    if (in_ready[0] !== 1'b1) begin
      errors++;
      $display("FAIL midreset_ready_return: got %b, required 1", in_ready[0]);
    end
    checks++;
    if (bit_q[0].size() - b0 != 3 || done_q[0].size() != d0) begin
      errors++;
      $display("FAIL midreset_discard: got %0d bits/%0d done, required 3/0",
               bit_q[0].size() - b0, done_q[0].size() - d0);
    end
    b0 = bit_q[0].size();
    send(0, 8'h0F, acc);
    wait_idle(0);
    checks++;
    if (bit_q[0].size() - b0 != 8 || done_q[0].size() - d0 != 1) begin
      errors++;
      $display("FAIL midreset_next_len: got %0d bits/%0d done, required 8/1",
               bit_q[0].size() - b0, done_q[0].size() - d0);
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (bit_q[0][b0+i] !== ((i >= 4) ? 1'b1 : 1'b0)) begin
          errors++;
          $display("FAIL midreset_next_bit%0d: got %b, required %b", i, bit_q[0][b0+i], (i >= 4));
        end
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    rst_n    = 1'b0;
    in_valid = '0;
    for (int d = 0; d < N; d++) in_data[d] = 8'h00;
    test_reset();
    test_single();
    test_back_to_back();
    test_gap();
    test_backpressure();
    test_lsb_first();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
